// File: rtl/pool_job_scheduler_if.sv
// Job descriptor push channel plus the start/done/abort handshake and job size to the pool engine.
// master is the software/engine side, slave is the scheduler.
interface pool_job_scheduler_if;
   logic       job_valid;
   logic       job_ready;
   logic [7:0] job_width;
   logic [8:0] job_length;
   logic [7:0] job_height;
   logic       pool_start;
   logic       pool_done;
   logic       pool_abort;
   logic [7:0] width;
   logic [8:0] length;
   logic [7:0] height;

   modport master (
      output job_valid, job_width, job_length, job_height, pool_done,
      input  job_ready, pool_start, pool_abort, width, length, height
   );

   modport slave (
      input  job_valid, job_width, job_length, job_height, pool_done,
      output job_ready, pool_start, pool_abort, width, length, height
   );
endinterface

// File: rtl/pool_job_scheduler.sv
// Queues pool job descriptors and launches them one at a time into the pool engine.
// Optional watchdog in RUN is enabled by defining POOL_SCHED_TIMEOUT_EN.
module pool_job_scheduler #(
   parameter int DEPTH          = 4,
   parameter int CNT_W          = 32,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                     CLK,
   input  logic                     RESET,
   pool_job_scheduler_if.slave      bus,
   input  logic                     sched_en,
   input  logic                     flush,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [CNT_W-1:0]         jobs_done,
   output logic [CNT_W-1:0]         jobs_skipped,
   output logic [CNT_W-1:0]         last_cycles,
   output logic                     err_timeout,
   input  logic                     err_clear
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LAUNCH = 2'd1;
   localparam logic [1:0] RUN    = 2'd2;

   logic [1:0]       state;
   logic [24:0]      mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [24:0]      head;
   logic             head_ok;
   logic             push;
   logic             pop;
   logic             launch;
   logic             skip;
   logic             done_evt;
   logic             timeout_evt;
   logic [CNT_W-1:0] run_cnt;
   logic [CNT_W-1:0] run_cnt_inc;

   // Descriptor packing: {height, length, width}; a zero in any field means the job is dropped.
   assign head     = mem[rd_ptr];
   assign head_ok  = (head[7:0] != 8'd0) && (head[16:8] != 9'd0) && (head[24:17] != 8'd0);

   assign bus.job_ready  = (fifo_count < CW'(DEPTH));
   assign push           = bus.job_valid && bus.job_ready;
   assign pop            = (state == IDLE) && sched_en && (fifo_count != '0) && !flush;
   assign launch         = pop && head_ok;
   assign skip           = pop && !head_ok;
   assign done_evt       = (state == RUN) && bus.pool_done;
   assign run_cnt_inc    = (run_cnt == '1) ? run_cnt : run_cnt + CNT_W'(1);
   assign bus.pool_start = (state == LAUNCH);
   assign busy           = (state != IDLE);

   always_ff @(posedge CLK) begin
      if (push && !flush) begin
         mem[wr_ptr] <= {bus.job_height, bus.job_length, bus.job_width};
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else if (flush) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // run_cnt holds cycles elapsed since the LAUNCH cycle, so the completed job length is run_cnt_inc.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state        <= IDLE;
         bus.width    <= '0;
         bus.length   <= '0;
         bus.height   <= '0;
         run_cnt      <= '0;
         jobs_done    <= '0;
         jobs_skipped <= '0;
         last_cycles  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (launch) begin
                  state      <= LAUNCH;
                  bus.width  <= head[7:0];
                  bus.length <= head[16:8];
                  bus.height <= head[24:17];
                  run_cnt    <= '0;
               end
               if (skip) begin
                  jobs_skipped <= jobs_skipped + CNT_W'(1);
               end
            end
            LAUNCH: begin
               state   <= RUN;
               run_cnt <= run_cnt_inc;
            end
            RUN: begin
               if (done_evt) begin
                  state       <= IDLE;
                  jobs_done   <= jobs_done + CNT_W'(1);
                  last_cycles <= run_cnt_inc;
               end else if (timeout_evt) begin
                  state <= IDLE;
               end else begin
                  run_cnt <= run_cnt_inc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef POOL_SCHED_TIMEOUT_EN
   // Completion on the same cycle as the limit takes priority over the watchdog.
   assign timeout_evt = (state == RUN) && !bus.pool_done && (run_cnt_inc >= CNT_W'(TIMEOUT_CYCLES));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         err_timeout    <= 1'b0;
         bus.pool_abort <= 1'b0;
      end else begin
         bus.pool_abort <= timeout_evt;
         if (timeout_evt) begin
            err_timeout <= 1'b1;
         end else if (err_clear) begin
            err_timeout <= 1'b0;
         end
      end
   end
`else
   logic             unused_err_clear;
   logic [CNT_W-1:0] unused_timeout;

   assign timeout_evt      = 1'b0;
   assign err_timeout      = 1'b0;
   assign bus.pool_abort   = 1'b0;
   assign unused_err_clear = err_clear;
   assign unused_timeout   = CNT_W'(TIMEOUT_CYCLES);
`endif
endmodule

// File: doc/pool_job_scheduler.md
# pool_job_scheduler

Sequences layer-by-layer pool jobs into the pool datapath. It buffers job descriptors in a small FIFO, with each descriptor holding width, length and height. Jobs are launched one at a time with a single-cycle start pulse, and the block waits for the done pulse before launching the next. It sits between the APB register block and the pool engine, replacing direct software writes of start and size, and reports per-job cycle counts, job totals and watchdog errors.

## Interface
Parameters:
- DEPTH, 4, descriptor FIFO entries; power of two, 2..16
- CNT_W, 32, width of the cycle and job counters
- TIMEOUT_CYCLES, 1000000, watchdog limit in RUN; used only with POOL_SCHED_TIMEOUT_EN

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- sched_en  in  1  launch enable; when 0, the block finishes the current job but launches no new job
- flush  in  1  one-cycle request that empties the FIFO; does not affect a running job
- job_valid  in  1  descriptor push request
- job_ready  out  1  FIFO can accept a descriptor
- job_width  in  8  descriptor width
- job_length  in  9  descriptor length
- job_height  in  8  descriptor height
- pool_start  out  1  one-cycle launch pulse to the pool engine
- pool_done  in  1  one-cycle completion pulse from the pool engine
- width  out  8  active job width; stable from LAUNCH until the next launch
- length  out  9  active job length; same stability rule as width
- height  out  8  active job height; same stability rule as width
- busy  out  1  high while in LAUNCH or RUN
- fifo_count  out  clog2(DEPTH)+1  number of queued descriptors
- jobs_done  out  CNT_W  number of completed jobs; wraps
- jobs_skipped  out  CNT_W  number of descriptors dropped for a zero dimension; wraps
- last_cycles  out  CNT_W  cycle count of the most recently completed job
- err_timeout  out  1  sticky watchdog error
- err_clear  in  1  clears err_timeout
- pool_abort  out  1  one-cycle abort pulse to the pool engine, issued on timeout

## Operation
- States:
  - IDLE: waits for a queued descriptor.
  - LAUNCH: asserts pool_start for exactly one cycle.
  - RUN: waits for pool_done.
- IDLE → LAUNCH when sched_en=1 and fifo_count>0 and the head descriptor has all dimensions nonzero.
  - On that edge, the head is popped and width, length and height are loaded from it.
- IDLE with sched_en=1, fifo_count>0 and any head dimension 0:
  - The head is popped and jobs_skipped increments.
  - The state stays IDLE and width, length and height are unchanged.
- LAUNCH → RUN unconditionally.
  - A pool_done pulse that arrives during LAUNCH or IDLE is ignored.
- RUN → IDLE on pool_done=1.
  - On that edge, jobs_done increments and last_cycles is loaded from the running counter.
- Running counter:
  - Cleared on entry to LAUNCH and incremented every cycle in LAUNCH and RUN.
  - The value loaded into last_cycles counts cycles from the LAUNCH cycle through the pool_done cycle inclusive.
  - The counter saturates at all-ones.
- Push: a descriptor is accepted on an edge with job_valid=1 and job_ready=1.
  - job_ready is 1 when fifo_count<DEPTH, evaluated from the registered count.
  - A push and a pop on the same edge leave fifo_count unchanged.
  - When the FIFO is full, job_ready=0 even if a pop occurs that cycle.
- Flush: on flush=1, fifo_count becomes 0 and the read and write pointers reset.
  - Flush wins over a push and a pop on the same edge; the pushed descriptor is discarded.
- err_clear: clears err_timeout. If a timeout set occurs on the same edge, the set wins.

## Timing
- Reset values:
  - State is IDLE.
  - pool_start=0, pool_abort=0, busy=0, job_ready=1.
  - fifo_count, width, length, height, jobs_done, jobs_skipped and last_cycles are all 0.
  - err_timeout=0.
- Launch latency: a descriptor pushed at edge T into an empty FIFO while IDLE with sched_en=1 gives:
  - pop and LAUNCH at edge T+1;
  - pool_start high during cycle T+1..T+2;
  - RUN from edge T+2.
- Minimum job period is 3 cycles: LAUNCH, then one RUN cycle with done, then IDLE.
- There is one IDLE cycle between consecutive jobs.
- Reset asserted mid-job drops the job immediately. No pool_abort pulse is produced; the pool engine shares RESET.
- Counters wrap modulo 2^CNT_W. last_cycles never wraps (the running counter saturates).

## Configuration
- POOL_SCHED_TIMEOUT_EN defined:
  - In RUN, when the running counter reaches TIMEOUT_CYCLES without pool_done, the block does all of the following on that edge:
    - goes to IDLE;
    - sets err_timeout;
    - pulses pool_abort for one cycle;
    - leaves jobs_done and last_cycles unchanged.
  - If pool_done arrives on the same cycle as the timeout, completion wins.
- POOL_SCHED_TIMEOUT_EN not defined:
  - There is no watchdog; RUN waits indefinitely.
  - pool_abort and err_timeout are tied to 0, and err_clear is ignored.

## Test plan
- Push (8,16,8) with sched_en=1; pool_done 10 cycles after pool_start → pool_start pulses once; width/length/height=8/16/8; jobs_done=1; last_cycles=11.
- Push 5 descriptors with DEPTH=4 and sched_en=0 → job_ready=0 after the 4th, 5th dropped, fifo_count=4; set sched_en=1 and run 4 dones → jobs_done=4; launched in FIFO order.
- Queue (0,16,8) followed by (4,4,4) → jobs_skipped=1; exactly one pool_start; width=4.
- Two jobs queued, pulse flush during the first job's RUN → first job completes normally, jobs_done=1, fifo_count=0, no second launch.
- With POOL_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=20, withhold pool_done → pool_abort pulses once; err_timeout=1; jobs_done=0; the next queued job launches; err_clear then returns err_timeout to 0.
- Assert RESET during RUN → all outputs return to reset values asynchronously; a later push launches normally.
